// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the core's single SRAM-like memory port between
// instruction fetch and the MEM-stage data requester. One transaction is in
// flight at a time; the winning request is latched so the bus side sees
// stable signals, and read data returns with a one-cycle ready pulse.
// Optional macro ARB_FAIR_EN: alternate grants under contention instead of
// the default fixed priority (data always beats fetch).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_ready,
  output logic                  inst_stall,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_ready,
  output logic                  data_stall,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                pick_data;
  logic                latch_en;
  logic                cap_en;

  logic                bus_req_q;
  logic                bus_wr_q;
  logic [STRB_W-1:0]   bus_wstrb_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                inst_ready_q;
  logic                data_ready_q;

`ifdef ARB_FAIR_EN
  owner_e              last_q;

  // Under contention the side not granted last wins; a lone requester always wins.
  always_comb begin
    pick_data = data_req & (~inst_req | (last_q == OWN_INST));
  end

  // Remember who won the most recent IDLE grant.
  always_ff @(posedge clk) begin
    if (!rst)          last_q <= OWN_INST;
    else if (latch_en) last_q <= owner_d;
  end
`else
  // Fixed priority: a pending data request always beats fetch.
  always_comb begin
    pick_data = data_req;
  end
`endif

  // Next-state logic: grant in IDLE, address handshake, wait for data, respond.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    latch_en = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req || inst_req) begin
          latch_en = 1'b1;
          owner_d  = pick_data ? OWN_DATA : OWN_INST;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            cap_en  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_data_ok) begin
          cap_en  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched bus request, captured read data and ready pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      bus_req_q <= (state_d == S_ADDR);
      if (latch_en) begin
        if (pick_data) begin
          bus_wr_q    <= data_wr;
          bus_wstrb_q <= data_wstrb;
          bus_addr_q  <= data_addr;
          bus_wdata_q <= data_wdata;
        end else begin
          bus_wr_q    <= 1'b0;
          bus_wstrb_q <= '0;
          bus_addr_q  <= inst_addr;
          bus_wdata_q <= '0;
        end
      end
      // Only the owner's rdata register moves; stores capture it too and the
      // requester simply ignores it.
      if (cap_en && owner_q == OWN_DATA) data_rdata_q <= bus_rdata;
      if (cap_en && owner_q == OWN_INST) inst_rdata_q <= bus_rdata;
      // Ready is high exactly while in RESP.
      inst_ready_q <= cap_en && (owner_q == OWN_INST);
      data_ready_q <= cap_en && (owner_q == OWN_DATA);
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_ready = inst_ready_q;
  assign data_ready = data_ready_q;
  assign inst_stall = inst_req & ~inst_ready_q;
  assign data_stall = data_req & ~data_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions are queued in
// grant order as stimulus is issued and retired on each ready pulse. A small
// port model answers bus requests with programmable handshake delays.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_ready, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_ready, data_stall;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ready(data_ready), .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        own;    // 1 = data requester
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int   addr_dly = 0;
  int   data_dly = 0;
  bit   same_cyc = 1'b0;
  bit   spur     = 1'b0;
  bit   abandon  = 1'b0;

`ifdef ARB_FAIR_EN
  localparam int ND = 2;
  localparam int NI = 2;
`else
  localparam int ND = 4;
  localparam int NI = 1;
`endif

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000)      return 32'h3C08_BFC0;
    else if (a == 32'h0000_0040) return 32'h1234_5678;
    else                         return a ^ 32'hA5A5_0F0F;
  endfunction

  function automatic txn_t mk(input logic own, input logic wr, input logic [3:0] st,
                              input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.own = own; t.wr = wr; t.wstrb = st; t.addr = a; t.wdata = wd;
    t.rdata = mem_fn(a);
    return t;
  endfunction

  // Port model: answers bus_req after addr_dly ADDR cycles, data after data_dly WAIT cycles.
  initial begin
    int ph, cnt;
    ph = 0; cnt = 0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      if (rst !== 1'b1) begin
        ph = 0;
      end else begin
        if (ph == 0) begin
          if (spur) begin
            bus_data_ok = 1'b1;
            bus_rdata   = 32'hFFFF_0000;
          end
          if (bus_req) begin
            ph  = 1;
            cnt = addr_dly;
          end
        end
        if (ph == 1) begin
          if (!abandon) begin
            if (sbq.size() == 0) begin
              chk("bus_unexpected", {31'd0, bus_req}, 64'd0);
            end else begin
              chk("bus_req",   {31'd0, bus_req}, 64'd1);
              chk("bus_wr",    {31'd0, bus_wr},  {31'd0, sbq[0].wr});
              chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, sbq[0].wstrb});
              chk("bus_addr",  {32'd0, bus_addr},  {32'd0, sbq[0].addr});
              chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, sbq[0].wdata});
            end
          end
          if (cnt == 0) begin
            bus_addr_ok = 1'b1;
            if (same_cyc) begin
              bus_data_ok = 1'b1;
              bus_rdata   = mem_fn(bus_addr);
              ph = 0;
            end else begin
              ph  = 2;
              cnt = data_dly;
            end
          end else begin
            cnt--;
          end
        end else if (ph == 2) begin
          if (cnt == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = mem_fn(bus_addr);
            ph = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Retire one scoreboard entry per ready pulse.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (inst_ready || data_ready)) begin
        chk("rdy_excl", {63'd0, inst_ready & data_ready}, 64'd0);
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ready", {62'd0, inst_ready, data_ready}, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("owner", {63'd0, data_ready}, {63'd0, e.own});
          chk("rdata", {32'd0, (data_ready ? data_rdata : inst_rdata)}, {32'd0, e.rdata});
        end
      end
    end
  end

  task automatic do_inst(input logic [31:0] a, output int lat);
    inst_addr = a; inst_req = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!inst_ready) chk("inst_stall", {63'd0, inst_stall}, 64'd1);
    end while (!inst_ready && lat < 200);
    chk("inst_done", {63'd0, inst_ready}, 64'd1);
    chk("inst_stall_rdy", {63'd0, inst_stall}, 64'd0);
    inst_req = 1'b0;
  endtask

  task automatic do_data(input logic wr, input logic [3:0] st, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
    data_wr = wr; data_wstrb = st; data_addr = a; data_wdata = wd;
    data_req = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!data_ready) chk("data_stall", {63'd0, data_stall}, 64'd1);
    end while (!data_ready && lat < 200);
    chk("data_done", {63'd0, data_ready}, 64'd1);
    chk("data_stall_rdy", {63'd0, data_stall}, 64'd0);
    data_req = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req",    {63'd0, bus_req}, 64'd0);
    chk("rst_bus_addr",   {32'd0, bus_addr}, 64'd0);
    chk("rst_ready",      {62'd0, inst_ready, data_ready}, 64'd0);
    chk("rst_inst_rdata", {32'd0, inst_rdata}, 64'd0);
    chk("rst_data_rdata", {32'd0, data_rdata}, 64'd0);
    rst = 1'b1;

    // Fetch only, fastest handshake.
    sbq.push_back(mk(1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0));
    do_inst(32'hBFC0_0000, lat);
    chk("fetch_lat", lat, 64'd3);
    @(negedge clk);
    chk("fetch_pulse_once", {63'd0, inst_ready}, 64'd0);

    // Store with addr_ok held off two cycles.
    addr_dly = 2;
    sbq.push_back(mk(1'b1, 1'b1, 4'h3, 32'h8000_1000, 32'hDEAD_BEEF));
    do_data(1'b1, 4'h3, 32'h8000_1000, 32'hDEAD_BEEF, lat);
    chk("store_lat", lat, 64'd5);
    @(negedge clk);
    chk("store_pulse_once", {63'd0, data_ready}, 64'd0);

    // addr_ok and data_ok in the same ADDR cycle.
    addr_dly = 0; same_cyc = 1'b1;
    sbq.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0));
    do_inst(32'h0000_0040, lat);
    chk("same_cyc_lat", lat, 64'd2);
    same_cyc = 1'b0;

    // Spurious data_ok while idle: nothing moves, rdata registers hold.
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_bus_req", {63'd0, bus_req}, 64'd0);
    chk("spur_ready",   {62'd0, inst_ready, data_ready}, 64'd0);
    chk("hold_inst_rdata", {32'd0, inst_rdata}, {32'd0, 32'h1234_5678});
    chk("hold_data_rdata", {32'd0, data_rdata}, {32'd0, mem_fn(32'h8000_1000)});

    // Contention; last grant so far was fetch.
    addr_dly = 1; data_dly = 1;
`ifdef ARB_FAIR_EN
    for (int k = 0; k < 2; k++) begin
      sbq.push_back(mk(1'b1, k[0], k[0] ? 4'hF : 4'h0, 32'h0000_1000 + 32'(16*k), 32'hC0DE_0000 + 32'(k)));
      sbq.push_back(mk(1'b0, 1'b0, 4'h0, 32'hBFC0_0100 + 32'(4*k), 32'h0));
    end
`else
    for (int k = 0; k < 4; k++)
      sbq.push_back(mk(1'b1, k[0], k[0] ? 4'hF : 4'h0, 32'h0000_1000 + 32'(16*k), 32'hC0DE_0000 + 32'(k)));
    sbq.push_back(mk(1'b0, 1'b0, 4'h0, 32'hBFC0_0100, 32'h0));
`endif
    fork
      begin
        int l;
        for (int k = 0; k < ND; k++)
          do_data(k[0], k[0] ? 4'hF : 4'h0, 32'h0000_1000 + 32'(16*k), 32'hC0DE_0000 + 32'(k), l);
      end
      begin
        int l;
        for (int k = 0; k < NI; k++)
          do_inst(32'hBFC0_0100 + 32'(4*k), l);
      end
    join
    @(negedge clk);
    chk("contention_drained", sbq.size(), 64'd0);

    // Reset while waiting for data: transaction abandoned, no ready pulse.
    abandon = 1'b1; addr_dly = 0; data_dly = 5;
    data_wr = 1'b0; data_wstrb = '0; data_addr = 32'h0000_2000; data_wdata = '0;
    data_req = 1'b1;
    @(negedge clk);
    chk("abort_addr_req",  {63'd0, bus_req}, 64'd1);
    chk("abort_addr_addr", {32'd0, bus_addr}, {32'd0, 32'h0000_2000});
    @(negedge clk);
    chk("abort_wait_req", {63'd0, bus_req}, 64'd0);
    rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    chk("abort_bus_req",    {63'd0, bus_req}, 64'd0);
    chk("abort_ready",      {62'd0, inst_ready, data_ready}, 64'd0);
    chk("abort_bus_addr",   {32'd0, bus_addr}, 64'd0);
    chk("abort_data_rdata", {32'd0, data_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1; abandon = 1'b0; data_dly = 0;
    repeat (8) @(negedge clk);
    chk("abort_no_pulse", {62'd0, inst_ready, data_ready}, 64'd0);

    // Recovery: a normal fetch after the abort.
    sbq.push_back(mk(1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0));
    do_inst(32'hBFC0_0000, lat);
    chk("recover_lat", lat, 64'd3);
    @(negedge clk);
    chk("sb_empty", sbq.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
